rx_receiver: RTL and testbench
==============================

RX_RECEIVER -- requirements
Module: rx_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434: clk cycles per serial bit (50 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  system clock (CLOCK_50); the block uses one clock.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port rx_line  input  1  serial line from the peer transmitter GPIO; idles high.
REQ-005 SHALL have port rx_data  output  8  payload data byte of the last accepted frame.
REQ-006 SHALL have port rx_mode  output  2  mode field of the last accepted frame.
REQ-007 SHALL have port rx_valid  output  1  one-cycle pulse when a frame completes, good or bad.
REQ-008 SHALL have port crc_ok  output  1  last frame's CRC matched; held until next rx_valid.
REQ-009 SHALL have port crc_err  output  1  last frame's CRC mismatched; held until next rx_valid.
REQ-010 SHALL have port frame_err  output  1  last frame had a bad sync byte or stop bit; held until next rx_valid.
REQ-011 SHALL have port busy  output  1  high from start-bit detection until rx_valid.

Function
REQ-012 Frame format SHALL be: start bit (0), 136 packet bits MSB first (bit 135 first), stop bit (1); one bit per CLKS_PER_BIT cycles.
REQ-013 Packet layout SHALL be: [135:128] sync 8'h7E; [127:120] {6'b0, mode}; [119:40] reserved; [39:32] data; [31:0] CRC-32.
REQ-014 CRC SHALL be: poly 0x04C11DB7, init 0xFFFFFFFF, MSB-first, no reflection, no final XOR, over packet bits [127:32] (96 bits), updated serially, one bit per sample.
REQ-015 rx_line SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-016 FSM states SHALL be IDLE, START, DATA, STOP, DONE.
REQ-017 IDLE: on a synchronized falling edge, go to START with bit counter = 0 and clock counter = 0; busy asserts.
REQ-018 START: at CLKS_PER_BIT/2 (integer division), sample the line; if 0, go to DATA with clock counter reset; if 1 (glitch), go back to IDLE with no rx_valid.
REQ-019 DATA: sample every CLKS_PER_BIT cycles at mid-bit, shift into a 136-bit shift register, and feed the CRC when bit index is 8..103; after the 136th sample, go to STOP.
REQ-020 STOP: after CLKS_PER_BIT cycles, sample the line; stop bit = the sampled value; go to DONE.
REQ-021 DONE (one cycle): update rx_data, rx_mode, crc_ok, crc_err and frame_err, then pulse rx_valid; return to IDLE with busy low.
REQ-022 frame_err SHALL be 1 when sync != 8'h7E or the stop bit = 0.
REQ-023 crc_ok SHALL be (computed CRC == packet[31:0]) AND NOT frame_err; crc_err SHALL be NOT crc_ok.
REQ-024 A falling edge during DATA or STOP SHALL NOT restart the frame.
REQ-025 A line held low through IDLE SHALL NOT start a new frame until the line has been high for at least one cycle (arm flag).
REQ-026 Latency from the stop-bit mid-sample to rx_valid SHALL be 1 cycle.

Reset
REQ-027 On rst: state = IDLE; counters = 0; CRC = 0xFFFFFFFF; arm flag = 0; synchronizer flops = 1.
REQ-028 On rst: rx_data = 0, rx_mode = 0, rx_valid = 0, crc_ok = 0, crc_err = 0, frame_err = 0, busy = 0.
REQ-029 rst in the middle of a frame SHALL abandon it with no rx_valid; reception resumes only after the line is seen high.

Structure
REQ-030 Shared package rx_pkg SHALL hold the FSM state enum, SYNC_BYTE = 8'h7E, CRC_POLY, CRC_INIT, PKT_W = 136, and the field bit positions.
REQ-031 The serial CRC SHALL be a sub-module rx_crc32_serial (ports: clk, rst, init, en, din, crc[31:0]), also reused by the transmitter.

Verification (CLKS_PER_BIT = 8)
REQ-032 Frame with mode = 2'b01, data = 8'hA5, valid CRC -> one rx_valid; rx_data = 8'hA5, rx_mode = 1, crc_ok = 1, frame_err = 0.
REQ-033 Same frame with packet bit 36 inverted (test-mode injection) -> rx_valid; rx_data = 8'hB5, crc_err = 1, crc_ok = 0.
REQ-034 Sync byte 8'h7F or stop bit 0 -> rx_valid with frame_err = 1 and crc_ok = 0.
REQ-035 3-cycle low glitch on an idle line -> no rx_valid, busy deasserts within 5 cycles, and a following good frame is accepted.
REQ-036 rst asserted at packet bit 60 with the line held low for 20 cycles, then a good frame -> exactly one rx_valid, for the second frame.
REQ-037 Two back-to-back frames (data 8'h00 then 8'hFF, one idle bit between them) -> two rx_valid pulses with the correct data and crc_ok = 1 each.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared definitions for the serial packet receiver and its transmitter peer:
// FSM encodings, packet field positions and the serial CRC-32 step.
package rx_pkg;

  localparam int PKT_W = 136;

  localparam logic [7:0]  SYNC_BYTE = 8'h7E;
  localparam logic [31:0] CRC_POLY  = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT  = 32'hFFFFFFFF;

  localparam int SYNC_MSB = 135;
  localparam int SYNC_LSB = 128;
  localparam int MODE_MSB = 121;
  localparam int MODE_LSB = 120;
  localparam int RSV_MSB  = 119;
  localparam int RSV_LSB  = 40;
  localparam int DATA_MSB = 39;
  localparam int DATA_LSB = 32;
  localparam int CRC_MSB  = 31;
  localparam int CRC_LSB  = 0;

  // Sample indices (0 = first packet bit on the wire) covered by the CRC,
  // i.e. packet bits [127:32].
  localparam int CRC_FIRST_IDX = 8;
  localparam int CRC_LAST_IDX  = 103;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t ST_IDLE  = 3'd0;
  localparam rx_state_t ST_START = 3'd1;
  localparam rx_state_t ST_DATA  = 3'd2;
  localparam rx_state_t ST_STOP  = 3'd3;
  localparam rx_state_t ST_DONE  = 3'd4;

  function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic din);
    logic fb;
    fb = crc[31] ^ din;
    return {crc[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/rx_crc32_serial.sv
// Bit-serial CRC-32 (MSB first, no reflection, no final XOR); shared with the
// transmitter so both ends compute the checksum identically.
module rx_crc32_serial
  import rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic        din,
  output logic [31:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || init) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc32_step(crc, din);
    end
  end

endmodule

// File: rtl/rx_receiver.sv
// Serial packet receiver: start bit, 136-bit MSB-first packet, stop bit.
// Checks sync byte, stop bit and CRC-32, then reports the payload with a pulse.
module rx_receiver
  import rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_line,
  output logic [7:0] rx_data,
  output logic [1:0] rx_mode,
  output logic       rx_valid,
  output logic       crc_ok,
  output logic       crc_err,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_CLK = 16'(CLKS_PER_BIT / 2);
  localparam logic [7:0]  LAST_BIT = 8'(PKT_W - 1);
  localparam logic [7:0]  CRC_FIRST = 8'(CRC_FIRST_IDX);
  localparam logic [7:0]  CRC_LAST  = 8'(CRC_LAST_IDX);

  rx_state_t          state;
  logic [15:0]        clk_cnt;
  logic [7:0]         bit_cnt;
  logic               arm;
  logic [1:0]         sync_fill;
  logic               rx_meta_p0;
  logic               rx_sync_p1;
  logic [PKT_W-1:0]   shift_reg;
  logic [31:0]        crc_val;
  logic               start_det;
  logic               bit_tick;
  logic               crc_en;
  logic               sync_bad;
  logic               frame_bad;
  logic               crc_match;
  logic               reserved_unused;

  // Two-flop synchronizer; flops preset high so reset looks like an idle line
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_meta_p0 <= rx_line;
      rx_sync_p1 <= rx_meta_p0;
    end
  end

  assign start_det = (state == ST_IDLE) && arm && !rx_sync_p1;
  assign bit_tick  = (clk_cnt == LAST_CLK);
  assign crc_en    = (state == ST_DATA) && bit_tick &&
                     (bit_cnt >= CRC_FIRST) && (bit_cnt <= CRC_LAST);

  rx_crc32_serial u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (start_det),
    .en   (crc_en),
    .din  (rx_sync_p1),
    .crc  (crc_val)
  );

  always_ff @(posedge clk) begin
    if ((state == ST_DATA) && bit_tick) begin
      shift_reg <= {shift_reg[PKT_W-2:0], rx_sync_p1};
    end
  end

  always_comb begin
    sync_bad  = 1'b0;
    frame_bad = 1'b0;
    crc_match = 1'b0;
    sync_bad  = (shift_reg[SYNC_MSB:SYNC_LSB] != SYNC_BYTE);
    frame_bad = sync_bad || !rx_sync_p1;
    crc_match = (crc_val == shift_reg[CRC_MSB:CRC_LSB]);
  end

  assign reserved_unused = ^{shift_reg[SYNC_LSB-1:MODE_MSB+1], shift_reg[RSV_MSB:RSV_LSB]};

  // sync_fill marks when the synchronizer carries real line samples, so the
  // reset preset of the flops can never arm a start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      arm       <= 1'b0;
      sync_fill <= 2'b00;
      busy      <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      rx_mode   <= '0;
      crc_ok    <= 1'b0;
      crc_err   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      sync_fill <= {sync_fill[0], 1'b1};
      case (state)
        ST_IDLE: begin
          if (start_det) begin
            state   <= ST_START;
            clk_cnt <= '0;
            bit_cnt <= '0;
            arm     <= 1'b0;
            busy    <= 1'b1;
          end else if (rx_sync_p1 && sync_fill[1]) begin
            arm <= 1'b1;
          end
        end
        ST_START: begin
          if (clk_cnt == HALF_CLK) begin
            clk_cnt <= '0;
            if (!rx_sync_p1) begin
              state <= ST_DATA;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            clk_cnt <= '0;
            bit_cnt <= bit_cnt + 8'd1;
            if (bit_cnt == LAST_BIT) begin
              state <= ST_STOP;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_tick) begin
            clk_cnt   <= '0;
            state     <= ST_DONE;
            rx_data   <= shift_reg[DATA_MSB:DATA_LSB];
            rx_mode   <= shift_reg[MODE_MSB:MODE_LSB];
            frame_err <= frame_bad;
            crc_ok    <= crc_match && !frame_bad;
            crc_err   <= !(crc_match && !frame_bad);
            rx_valid  <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_receiver.sv
// Scoreboard bench for rx_receiver at 8 clocks per bit.
module tb_rx_receiver;

  localparam int CPB = 8;

  logic       clk;
  logic       rst;
  logic       rx_line;
  logic [7:0] rx_data;
  logic [1:0] rx_mode;
  logic       rx_valid;
  logic       crc_ok;
  logic       crc_err;
  logic       frame_err;
  logic       busy;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] mode;
    logic       ok;
    logic       err;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_errors;
  int   n_valid;

  rx_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_line   (rx_line),
    .rx_data   (rx_data),
    .rx_mode   (rx_mode),
    .rx_valid  (rx_valid),
    .crc_ok    (crc_ok),
    .crc_err   (crc_err),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [135:0] make_pkt(input logic [7:0] sync, input logic [1:0] mode,
                                            input logic [79:0] rsv, input logic [7:0] data);
    logic [95:0] body;
    logic [31:0] c;
    logic        fb;
    body = {6'b0, mode, rsv, data};
    c = 32'hFFFFFFFF;
    for (int i = 95; i >= 0; i--) begin
      fb = c[31] ^ body[i];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ 32'h04C11DB7;
    end
    return {sync, body, c};
  endfunction

  task automatic drive_bit(input logic b);
    rx_line = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx_line = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  // abort_at >= 0 resets the DUT mid-packet with the line held low.
  task automatic send_frame(input logic [135:0] pkt, input logic stop_b, input int abort_at);
    drive_bit(1'b0);
    for (int i = 0; i < 136; i++) begin
      if (i == abort_at) begin
        rx_line = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy_cleared", {31'b0, busy}, 32'd0);
        repeat (20) @(negedge clk);
        rx_line = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        return;
      end
      drive_bit(pkt[135 - i]);
    end
    drive_bit(stop_b);
    rx_line = 1'b1;
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic [1:0] m,
                              input logic ok, input logic ferr);
    exp_t e;
    e.data = d;
    e.mode = m;
    e.ok   = ok;
    e.err  = ~ok;
    e.ferr = ferr;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && rx_valid === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        check("unexpected_rx_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rx_data",   {24'b0, rx_data},   {24'b0, e.data});
        check("rx_mode",   {30'b0, rx_mode},   {30'b0, e.mode});
        check("crc_ok",    {31'b0, crc_ok},    {31'b0, e.ok});
        check("crc_err",   {31'b0, crc_err},   {31'b0, e.err});
        check("frame_err", {31'b0, frame_err}, {31'b0, e.ferr});
      end
    end
  end

  initial begin
    logic [135:0] pkt;
    logic         saw_hi;
    logic         dropped;
    n_checks = 0;
    n_errors = 0;
    n_valid  = 0;
    rst      = 1'b1;
    rx_line  = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_rx_data",   {24'b0, rx_data},   32'd0);
    check("rst_rx_mode",   {30'b0, rx_mode},   32'd0);
    check("rst_rx_valid",  {31'b0, rx_valid},  32'd0);
    check("rst_crc_ok",    {31'b0, crc_ok},    32'd0);
    check("rst_crc_err",   {31'b0, crc_err},   32'd0);
    check("rst_frame_err", {31'b0, frame_err}, 32'd0);
    check("rst_busy",      {31'b0, busy},      32'd0);
    rst = 1'b0;
    idle_bits(3);

    // Good frame, mode 1, data A5
    pkt = make_pkt(8'h7E, 2'b01, 80'h0123_4567_89AB_CDEF_5A5A, 8'hA5);
    expect_frame(8'hA5, 2'b01, 1'b1, 1'b0);
    send_frame(pkt, 1'b1, -1);
    idle_bits(2);

    // Same frame with packet bit 36 flipped: data becomes B5, CRC no longer matches
    pkt[36] = ~pkt[36];
    expect_frame(8'hB5, 2'b01, 1'b0, 1'b0);
    send_frame(pkt, 1'b1, -1);
    idle_bits(2);

    // Bad sync byte with an otherwise valid CRC
    pkt = make_pkt(8'h7F, 2'b10, 80'h0, 8'h3C);
    expect_frame(8'h3C, 2'b10, 1'b0, 1'b1);
    send_frame(pkt, 1'b1, -1);
    idle_bits(2);

    // Stop bit low
    pkt = make_pkt(8'h7E, 2'b11, 80'hFFFF_0000_FFFF_0000_FFFF, 8'h5A);
    expect_frame(8'h5A, 2'b11, 1'b0, 1'b1);
    send_frame(pkt, 1'b0, -1);
    idle_bits(3);

    // Three-cycle glitch on an idle line
    rx_line = 1'b0;
    repeat (3) @(negedge clk);
    rx_line = 1'b1;
    saw_hi  = 1'b0;
    dropped = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) saw_hi = 1'b1;
      if (saw_hi && !busy) dropped = 1'b1;
    end
    check("glitch_busy_seen", {31'b0, saw_hi},  32'd1);
    check("glitch_busy_drop", {31'b0, dropped}, 32'd1);
    idle_bits(2);
    pkt = make_pkt(8'h7E, 2'b00, 80'hDEAD_BEEF_0000_1111_2222, 8'hC3);
    expect_frame(8'hC3, 2'b00, 1'b1, 1'b0);
    send_frame(pkt, 1'b1, -1);
    idle_bits(2);

    // Reset mid-packet, then a good frame
    pkt = make_pkt(8'h7E, 2'b01, 80'h0, 8'h11);
    send_frame(pkt, 1'b1, 60);
    idle_bits(1);
    pkt = make_pkt(8'h7E, 2'b10, 80'h1357_9BDF_2468_ACE0_FFFF, 8'h96);
    expect_frame(8'h96, 2'b10, 1'b1, 1'b0);
    send_frame(pkt, 1'b1, -1);
    idle_bits(2);

    // Back-to-back frames with one idle bit between them
    pkt = make_pkt(8'h7E, 2'b01, 80'h0, 8'h00);
    expect_frame(8'h00, 2'b01, 1'b1, 1'b0);
    send_frame(pkt, 1'b1, -1);
    idle_bits(1);
    pkt = make_pkt(8'h7E, 2'b01, 80'h0, 8'hFF);
    expect_frame(8'hFF, 2'b01, 1'b1, 1'b0);
    send_frame(pkt, 1'b1, -1);
    idle_bits(4);

    check("pending_expected_frames", exp_q.size(), 32'd0);
    check("rx_valid_count", n_valid, 32'd8);
    check("idle_busy_low", {31'b0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
